// File: rtl/pad_pkg.sv
// ----------------------------------------------------------------------------
// pad_pkg
// Shared definitions for the DualShock pad button event logic.
//   PAD_BTN_W   : buttons per pad
//   pad_btn_t   : one pad's button word
//   Button index constants give the bit position of each button in a pad word.
// ----------------------------------------------------------------------------
package pad_pkg;

    localparam int PAD_BTN_W = 16;

    typedef logic [PAD_BTN_W-1:0] pad_btn_t;

    localparam int SELECT   = 0;
    localparam int L3       = 1;
    localparam int R3       = 2;
    localparam int START    = 3;
    localparam int UP       = 4;
    localparam int RIGHT    = 5;
    localparam int DOWN     = 6;
    localparam int LEFT     = 7;
    localparam int L2       = 8;
    localparam int R2       = 9;
    localparam int L1       = 10;
    localparam int R1       = 11;
    localparam int TRIANGLE = 12;
    localparam int CIRCLE   = 13;
    localparam int CROSS    = 14;
    localparam int SQUARE   = 15;

endpackage

// File: rtl/pad_button_cell.sv
// ----------------------------------------------------------------------------
// pad_button_cell
// Debounce, press/release events, auto-repeat and optional toggle latch for a
// single button. All timing advances only on sample_valid strobes.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   sample_valid in   strobe: raw holds a fresh poll sample
//   raw          in   gated raw level, 1 = pressed
//   pressed      out  debounced level
//   press_evt    out  1-cycle pulse on accepted press
//   release_evt  out  1-cycle pulse on accepted release
//   repeat_evt   out  1-cycle auto-repeat pulse while held
//   toggled      out  flips on each accepted press (PAD_TOGGLE_EN), else 0
//
// Build option: PAD_TOGGLE_EN adds the toggle latch; without it toggled is 0.
// ----------------------------------------------------------------------------
module pad_button_cell
    import pad_pkg::*;
#(
    parameter int STABLE_SAMPLES = 2,
    parameter int HOLD_SAMPLES   = 30,
    parameter int REPEAT_SAMPLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_valid,
    input  logic raw,
    output logic pressed,
    output logic press_evt,
    output logic release_evt,
    output logic repeat_evt,
    output logic toggled
);

    localparam int DW = $clog2(STABLE_SAMPLES + 1);
    localparam int RW = $clog2(HOLD_SAMPLES + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(STABLE_SAMPLES - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(HOLD_SAMPLES - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(HOLD_SAMPLES - REPEAT_SAMPLES);
    localparam logic [RW-1:0] REP_SAT    = RW'(HOLD_SAMPLES);

    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rep_cnt;
    logic          accept;

    // The sample that completes the run of differing samples flips the level.
    assign accept = (raw != pressed) && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed     <= 1'b0;
            deb_cnt     <= '0;
            rep_cnt     <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            repeat_evt  <= 1'b0;
            if (sample_valid) begin
                // debounce
                if (raw == pressed) begin
                    deb_cnt <= '0;
                end else if (accept) begin
                    pressed     <= raw;
                    deb_cnt     <= '0;
                    press_evt   <= raw;
                    release_evt <= ~raw;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end

                // auto-repeat: a sample accepting a press sees pressed==0 and
                // clears; a sample accepting a release is suppressed.
                if (!pressed || accept) begin
                    rep_cnt <= '0;
                end else if (rep_cnt == REP_LAST) begin
                    repeat_evt <= 1'b1;
                    rep_cnt    <= REP_RELOAD;
                end else if (rep_cnt != REP_SAT) begin
                    // REP_SAT is only reached with repeat disabled; park there.
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PAD_TOGGLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggled <= 1'b0;
        end else if (sample_valid && accept && raw) begin
            toggled <= ~toggled;
        end
    end
`else
    assign toggled = 1'b0;
`endif

endmodule

// File: rtl/pad_button_events.sv
// ----------------------------------------------------------------------------
// pad_button_events
// Per-button debounce and event generator for NUM_PADS DualShock pads.
// Converts active-low raw button words into debounced active-high levels and
// emits press, release and auto-repeat pulses. Timing counts poll samples.
//
// Ports (pad p occupies bits [16p +: 16] of every bus):
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   sample_valid   in   strobe: pad_buttons_n holds a fresh poll sample
//   pad_present    in   pad p answered the poll; 0 forces its buttons released
//   pad_buttons_n  in   raw buttons, 0 = pressed
//   pressed        out  debounced level, 1 = pressed
//   press_evt      out  1-cycle pulse: press accepted
//   release_evt    out  1-cycle pulse: release accepted
//   repeat_evt     out  1-cycle pulse: auto-repeat while held
//   toggled        out  press-toggled latch (PAD_TOGGLE_EN), else 0
//
// Build option: PAD_TOGGLE_EN enables the toggle latches in every cell.
// ----------------------------------------------------------------------------
module pad_button_events
    import pad_pkg::*;
#(
    parameter int NUM_PADS       = 2,
    parameter int STABLE_SAMPLES = 2,
    parameter int HOLD_SAMPLES   = 30,
    parameter int REPEAT_SAMPLES = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [NUM_PADS-1:0]           pad_present,
    input  logic [NUM_PADS*PAD_BTN_W-1:0] pad_buttons_n,
    output logic [NUM_PADS*PAD_BTN_W-1:0] pressed,
    output logic [NUM_PADS*PAD_BTN_W-1:0] press_evt,
    output logic [NUM_PADS*PAD_BTN_W-1:0] release_evt,
    output logic [NUM_PADS*PAD_BTN_W-1:0] repeat_evt,
    output logic [NUM_PADS*PAD_BTN_W-1:0] toggled
);

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_btn_t raw;

        // An absent pad reads as all released, so held buttons fall back
        // through the normal debounce path.
        assign raw = {PAD_BTN_W{pad_present[p]}} & ~pad_buttons_n[p*PAD_BTN_W +: PAD_BTN_W];

        for (genvar b = 0; b < PAD_BTN_W; b++) begin : g_btn
            pad_button_cell #(
                .STABLE_SAMPLES (STABLE_SAMPLES),
                .HOLD_SAMPLES   (HOLD_SAMPLES),
                .REPEAT_SAMPLES (REPEAT_SAMPLES)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .sample_valid (sample_valid),
                .raw          (raw[b]),
                .pressed      (pressed    [p*PAD_BTN_W + b]),
                .press_evt    (press_evt  [p*PAD_BTN_W + b]),
                .release_evt  (release_evt[p*PAD_BTN_W + b]),
                .repeat_evt   (repeat_evt [p*PAD_BTN_W + b]),
                .toggled      (toggled    [p*PAD_BTN_W + b])
            );
        end
    end

endmodule

// File: tb/tb_pad_button_events.sv
// ----------------------------------------------------------------------------
// tb_pad_button_events
// Directed bench for pad_button_events with default parameters
// (2 pads, STABLE_SAMPLES=2, HOLD_SAMPLES=30, REPEAT_SAMPLES=6).
// Expected toggled values follow PAD_TOGGLE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_pad_button_events;
    import pad_pkg::*;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [1:0]  pad_present;
    logic [31:0] pad_buttons_n;
    logic [31:0] pressed;
    logic [31:0] press_evt;
    logic [31:0] release_evt;
    logic [31:0] repeat_evt;
    logic [31:0] toggled;

    int vec_cnt;
    int miscompares;

    localparam logic [31:0] ALL_UP = 32'hFFFF_FFFF;

    pad_button_events dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .pad_present   (pad_present),
        .pad_buttons_n (pad_buttons_n),
        .pressed       (pressed),
        .press_evt     (press_evt),
        .release_evt   (release_evt),
        .repeat_evt    (repeat_evt),
        .toggled       (toggled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One poll sample; outputs are settled #1 after the capturing edge.
    task automatic poll(input logic [31:0] btn_n, input logic [1:0] pres);
        @(negedge clk);
        pad_buttons_n = btn_n;
        pad_present   = pres;
        sample_valid  = 1'b1;
        @(posedge clk);
        #1;
        sample_valid  = 1'b0;
    endtask

    function automatic logic [31:0] bit_of(input int idx);
        return 32'd1 << idx;
    endfunction

    logic [31:0] tog_exp;

    initial begin
        vec_cnt       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        sample_valid  = 1'b0;
        pad_present   = 2'b11;
        pad_buttons_n = ALL_UP;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // buttons held but no strobe: nothing may change
        pad_buttons_n = 32'h0000_0000;
        repeat (4) @(posedge clk);
        #1;
        check_vec("reset_pressed",  pressed,     32'h0);
        check_vec("reset_press",    press_evt,   32'h0);
        check_vec("reset_release",  release_evt, 32'h0);
        check_vec("reset_repeat",   repeat_evt,  32'h0);
        check_vec("reset_toggled",  toggled,     32'h0);

        // CROSS glitch of one sample is rejected
        poll(~bit_of(CROSS), 2'b11);
        check_vec("glitch_press",   press_evt, 32'h0);
        check_vec("glitch_level",   pressed,   32'h0);
        poll(ALL_UP, 2'b11);
        check_vec("glitch_after",   pressed,   32'h0);

        // CROSS held two samples is accepted on the second
        poll(~bit_of(CROSS), 2'b11);
        check_vec("cross_s1_press", press_evt, 32'h0);
        poll(~bit_of(CROSS), 2'b11);
        check_vec("cross_press",    press_evt, bit_of(CROSS));
        check_vec("cross_level",    pressed,   bit_of(CROSS));
        @(posedge clk);
        #1;
        check_vec("cross_pulse_end", press_evt, 32'h0);
        poll(ALL_UP, 2'b11);
        check_vec("cross_rel_s1",   release_evt, 32'h0);
        poll(ALL_UP, 2'b11);
        check_vec("cross_release",  release_evt, bit_of(CROSS));
        check_vec("cross_rel_level", pressed,    32'h0);

        // pad1 START held: repeats on the 30th, 36th and 42nd strobe after
        // the accepting strobe (counting that strobe as 1: samples 31/37/43)
        poll(~bit_of(16 + START), 2'b11);
        poll(~bit_of(16 + START), 2'b11);
        check_vec("start_press",    press_evt,  bit_of(16 + START));
        check_vec("start_no_rep",   repeat_evt, 32'h0);
        for (int k = 1; k <= 45; k++) begin
            poll(~bit_of(16 + START), 2'b11);
            check_vec($sformatf("start_rep_%0d", k), repeat_evt,
                      (k == 30 || k == 36 || k == 42) ? bit_of(16 + START) : 32'h0);
        end
        poll(ALL_UP, 2'b11);
        check_vec("start_rel_s1_rep", repeat_evt,  32'h0);
        check_vec("start_rel_s1",     release_evt, 32'h0);
        poll(ALL_UP, 2'b11);
        check_vec("start_release",    release_evt, bit_of(16 + START));
        check_vec("start_rel_rep",    repeat_evt,  32'h0);
        for (int k = 0; k < 8; k++) begin
            poll(ALL_UP, 2'b11);
            check_vec("start_quiet", repeat_evt | pressed, 32'h0);
        end

        // simultaneous presses on two pads
        poll(~(bit_of(UP) | bit_of(16 + SQUARE)), 2'b11);
        poll(~(bit_of(UP) | bit_of(16 + SQUARE)), 2'b11);
        check_vec("dual_press",   press_evt, bit_of(UP) | bit_of(16 + SQUARE));
        poll(ALL_UP, 2'b11);
        poll(ALL_UP, 2'b11);
        check_vec("dual_release", release_evt, bit_of(UP) | bit_of(16 + SQUARE));

        // L1 held, then pad 0 disappears while its raw bit stays low
        poll(~bit_of(L1), 2'b11);
        poll(~bit_of(L1), 2'b11);
        check_vec("l1_level",     pressed,     bit_of(L1));
        poll(~bit_of(L1), 2'b10);
        check_vec("l1_absent_s1", release_evt, 32'h0);
        poll(~bit_of(L1), 2'b10);
        check_vec("l1_absent_rel", release_evt, bit_of(L1));
        check_vec("l1_absent_lvl", pressed,     32'h0);
        poll(ALL_UP, 2'b11);
        poll(ALL_UP, 2'b11);

        // CIRCLE pressed and released twice
        tog_exp = 32'h0;
        for (int n = 0; n < 2; n++) begin
            poll(~bit_of(CIRCLE), 2'b11);
            poll(~bit_of(CIRCLE), 2'b11);
`ifdef PAD_TOGGLE_EN
            tog_exp = tog_exp ^ bit_of(CIRCLE);
`endif
            check_vec($sformatf("circle_tog_press%0d", n), toggled, tog_exp);
            poll(ALL_UP, 2'b11);
            poll(ALL_UP, 2'b11);
            check_vec($sformatf("circle_tog_rel%0d", n), toggled, tog_exp);
        end

        // reset in the middle of a hold clears at once
        poll(~bit_of(CROSS), 2'b11);
        poll(~bit_of(CROSS), 2'b11);
        check_vec("prerst_level", pressed, bit_of(CROSS));
        #1;
        rst = 1'b1;
        #1;
        check_vec("midrst_level",   pressed, 32'h0);
        check_vec("midrst_toggled", toggled, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        poll(~bit_of(CROSS), 2'b11);
        check_vec("postrst_s1", press_evt, 32'h0);
        poll(~bit_of(CROSS), 2'b11);
        check_vec("postrst_press", press_evt, bit_of(CROSS));
        check_vec("postrst_level", pressed,   bit_of(CROSS));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
